fix14_16_signed_div: RTL
========================

// Module: fix14_16_signed_div
// PURPOSE
// - Iterative signed divider for the fix 14.16 format (16-bit word, 14 fraction bits).
// - Computes quotient = (dividend << FRAC_W) / divisor, truncated toward zero, saturated to D_W bits.
// - Inverse companion to the SB_MAC16 fix 14.16 multiplier in the ADC DSP chain
//   (gain normalisation, ratio measurement).
// - Built from fabric logic, with no SB_MAC16; one quotient bit per clock.
// PARAMETERS
// - D_W     16  word width of dividend, divisor and quotient
// - FRAC_W  14  fraction bits; the numerator is D_W+FRAC_W bits wide (N_W = 30 at defaults)
// PORTS
// - sys_clk       in   1    system clock; all state changes on its rising edge
// - sys_rst       in   1    reset, synchronous, active-high
// - start         in   1    request; sampled only in IDLE
// - dividend      in   D_W  signed fix 14.16; sampled on the accepted start edge
// - divisor       in   D_W  signed fix 14.16; sampled on the accepted start edge
// - busy          out  1    high from the edge after accept until done falls
// - done          out  1    one-cycle pulse; quotient and flags are valid from this cycle
// - quotient      out  D_W  signed fix 14.16 result; holds until the next done
// - overflow      out  1    saturation occurred; valid with done, held with quotient
// - div_by_zero   out  1    divisor was 0; valid with done, held with quotient
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, quotient=0, overflow=0, div_by_zero=0; internal registers cleared.
// - Reset mid-operation: abort immediately to IDLE with the reset values above; no done pulse is produced.
// - FSM: IDLE -> CALC -> FIN -> IDLE.
// - IDLE: on start=1, latch the operands and go to CALC.
//   - Latch |dividend| and |divisor| as D_W+1-bit magnitudes; |-32768| = 32768 must not wrap.
//   - Latch neg = sign(dividend) XOR sign(divisor), and zero flag = (divisor == 0).
//   - Load numerator = |dividend| << FRAC_W; clear the partial remainder; bit counter = N_W-1.
// - CALC: one restoring-division step per cycle.
//   - rem = {rem, next numerator MSB}.
//   - If rem >= |divisor|: rem -= |divisor| and q_bit = 1; otherwise q_bit = 0.
//   - Shift q_bit into the N_W-bit magnitude register.
//   - Exactly N_W cycles; go to FIN when counter == 0.
// - FIN: apply sign, saturation and the zero check; register the outputs; done=1 for this one cycle; then IDLE.
//   - Zero divisor: quotient = dividend[D_W-1] ? 0x8000 : 0x7FFF; div_by_zero=1; overflow=0.
//     - The zero-divisor case uses the full fixed latency; there is no fast path.
//   - Positive result (neg=0), mag > 0x7FFF: quotient=0x7FFF, overflow=1.
//   - Negative result (neg=1), mag > 0x8000: quotient=0x8000, overflow=1.
//   - mag == 0x8000 with neg=1 is exact -2.0: quotient=0x8000, overflow=0.
//   - Otherwise: quotient = neg ? -mag : mag (two's complement), flags=0.
//   - A zero dividend with a nonzero divisor gives quotient=0 and no flags, regardless of neg.
// - Latency: start accepted at edge k; busy=1 after edges k+1..k+N_W+1; done=1 in the cycle after edge k+N_W+1.
//   - That is 31 cycles at the defaults.
// - Throughput: a new start is accepted on the cycle after done, i.e. back to IDLE.
//   - start is ignored while busy: no queueing, no restart.
//   - start asserted in the same cycle as done is ignored; it is honoured only in IDLE.
// - Operands may change freely after the accept edge; the block uses only its latched copies.
// - Rounding: truncate toward zero. The remainder is discarded and not exported.
// STRUCTURE
// - Shared include fix14_16_defs.vh (also used by the multiplier wrapper):
//   - localparams FIX_D_W=16, FIX_FRAC_W=14, FIX_MAX=16'h7FFF, FIX_MIN=16'h8000, FIX_ONE=16'h4000.
//   - State encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIN=2'd2.
// - Single module; no sub-module is needed.
//   - The restoring step is a small combinational compare/subtract inline in the CALC branch.
//   - Sign/abs and saturation logic stay local to this module.
// - Registers: state, counter ($clog2(N_W) bits), num shift register (N_W), rem (D_W+2), mag (N_W), neg, zero.
// TESTING
// 1. Basic: 0x2000 / 0x4000 (0.5/1.0) -> quotient=0x2000, flags 0.
//    Check done rises exactly 31 cycles after the start cycle.
// 2. Truncation and sign:
//    - 0x4000 / 0x6000 -> 0x2AAA.
//    - 0xC000 / 0x6000 -> 0xD556 (toward zero).
//    - 0x4000 / 0xA000 -> 0xD556.
// 3. Saturation:
//    - 0x4000 / 0x2000 (1.0/0.5) -> 0x7FFF, overflow=1.
//    - 0xC000 / 0x2000 -> 0x8000, overflow=0 (exact -2.0).
//    - 0x8000 / 0xC000 -> 0x7FFF, overflow=1.
// 4. Divide by zero:
//    - 0x1234 / 0x0000 -> 0x7FFF, div_by_zero=1.
//    - 0xF000 / 0x0000 -> 0x8000, div_by_zero=1.
//    - Same 31-cycle latency in both cases.
// 5. Handshake: pulse start again mid-CALC with other operands -> ignored, first result unchanged.
//    - start held continuously -> one result per 32 cycles.
//    - Outputs hold between done pulses.
// 6. Reset mid-CALC: assert sys_rst at cycle 10 -> next cycle busy=0 and quotient=0, and no done appears.
//    - A following 0x2000 / 0x4000 completes normally.

Source files
------------

// File: rtl/fix14_16_signed_div_pkg.sv
// ----------------------------------------------------------------------------
// fix14_16_signed_div_pkg
// Shared constants and state encoding for the fix 14.16 arithmetic blocks.
// The divider uses these definitions, and so does the SB_MAC16 multiplier
// wrapper.
//   FIX_D_W / FIX_FRAC_W : word width and number of fraction bits
//   FIX_MAX / FIX_MIN    : saturation limits, +1.99994 and -2.0
//   FIX_ONE              : 1.0 in this format
//   div_state_t          : divider FSM encoding
// ----------------------------------------------------------------------------
package fix14_16_signed_div_pkg;

   localparam int          FIX_D_W    = 16;
   localparam int          FIX_FRAC_W = 14;
   localparam logic [15:0] FIX_MAX    = 16'h7FFF;
   localparam logic [15:0] FIX_MIN    = 16'h8000;
   localparam logic [15:0] FIX_ONE    = 16'h4000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/fix14_16_signed_div_if.sv
// ----------------------------------------------------------------------------
// fix14_16_signed_div_if
// Request/result bundle of the fix 14.16 divider.
//   start, dividend, divisor                   : requester -> divider
//   busy, done, quotient, overflow, div_by_zero : divider -> requester
// modport master = requester side, modport slave = divider side.
// ----------------------------------------------------------------------------
interface fix14_16_signed_div_if #(parameter int D_W = 16);

   logic           start;
   logic [D_W-1:0] dividend;
   logic [D_W-1:0] divisor;
   logic           busy;
   logic           done;
   logic [D_W-1:0] quotient;
   logic           overflow;
   logic           div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, overflow, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, overflow, div_by_zero
   );

endinterface

// File: rtl/fix14_16_signed_div.sv
// ----------------------------------------------------------------------------
// fix14_16_signed_div
// Iterative signed divider for the fix 14.16 format. It computes
// (dividend << FRAC_W) / divisor, truncates the result toward zero, and
// saturates it to D_W bits. It is a restoring divider that produces one
// quotient bit per clock, so a result takes N_W + 1 cycles from accept to done.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus (slave)      : start/dividend/divisor in,
//                      busy/done/quotient/overflow/div_by_zero out
// ----------------------------------------------------------------------------
module fix14_16_signed_div
   import fix14_16_signed_div_pkg::*;
#(
   parameter int D_W    = FIX_D_W,
   parameter int FRAC_W = FIX_FRAC_W
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   fix14_16_signed_div_if.slave  bus
);

   localparam int N_W   = D_W + FRAC_W;
   localparam int CNT_W = $clog2(N_W);

   localparam logic [D_W-1:0] Q_MIN       = {1'b1, {(D_W-1){1'b0}}};
   localparam logic [D_W-1:0] Q_MAX       = ~Q_MIN;
   localparam logic [N_W-1:0] MAG_NEG_LIM = N_W'(1) << (D_W-1);
   localparam logic [N_W-1:0] MAG_POS_LIM = MAG_NEG_LIM - N_W'(1);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [N_W-1:0]   num;
   logic [D_W+1:0]   rem;
   logic [N_W-1:0]   mag;
   logic [D_W:0]     dvs_mag;
   logic             neg;
   logic             zero;

   logic             busy_q, done_q, ovf_q, dz_q;
   logic [D_W-1:0]   quot_q;

   // Combinational helpers.
   logic [D_W:0]     dvd_ext, dvs_ext, dvd_abs, dvs_abs;
   logic [D_W+1:0]   rem_sh, rem_sub;
   logic             rem_ge;
   logic [D_W-1:0]   q_nxt;
   logic             ovf_nxt, dz_nxt;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge sys_clk) begin
      // NOTE: every clocked register is assigned with <=, so all flops update
      // together and the order of the statements has no effect.
      if (sys_rst) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      // NOTE: the default comes first, so every path assigns state_nxt and
      // no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_CALC;
         ST_CALC: if (cnt == '0) state_nxt = ST_FIN;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------- operand magnitudes
   // Sign-extend by one bit before negating, so |-2^(D_W-1)| does not wrap.
   always_comb begin
      dvd_ext = {bus.dividend[D_W-1], bus.dividend};
      dvs_ext = {bus.divisor[D_W-1], bus.divisor};
      dvd_abs = dvd_ext[D_W] ? -dvd_ext : dvd_ext;
      dvs_abs = dvs_ext[D_W] ? -dvs_ext : dvs_ext;
   end

   // ------------------------------------------------ restoring step
   always_comb begin
      rem_sh  = {rem[D_W:0], num[N_W-1]};
      rem_ge  = (rem_sh >= {1'b0, dvs_mag});
      rem_sub = rem_sh - {1'b0, dvs_mag};
   end

   // ------------------------------------- sign, saturation, zero check
   // The zero divisor is tested first. In that case neg is the dividend sign,
   // because the divisor sign bit is 0. mag == MAG_NEG_LIM with neg set is
   // exactly -2.0; negating it gives Q_MIN and no overflow.
   always_comb begin
      q_nxt   = neg ? -mag[D_W-1:0] : mag[D_W-1:0];
      ovf_nxt = 1'b0;
      dz_nxt  = 1'b0;
      if (zero) begin
         q_nxt  = neg ? Q_MIN : Q_MAX;
         dz_nxt = 1'b1;
      end else if (!neg && (mag > MAG_POS_LIM)) begin
         q_nxt   = Q_MAX;
         ovf_nxt = 1'b1;
      end else if (neg && (mag > MAG_NEG_LIM)) begin
         q_nxt   = Q_MIN;
         ovf_nxt = 1'b1;
      end
   end

   // ------------------------------------------------------ datapath
   always_ff @(posedge sys_clk) begin
      // NOTE: there is no memory array here, so reset clears every register,
      // including the datapath, and an aborted run leaves nothing behind.
      if (sys_rst) begin
         cnt     <= '0;
         num     <= '0;
         rem     <= '0;
         mag     <= '0;
         dvs_mag <= '0;
         neg     <= 1'b0;
         zero    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // The registered copy of "not idle" goes high one edge after accept
         // and goes low on the edge where done falls.
         busy_q <= (state != ST_IDLE);
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  num     <= {dvd_abs[D_W-1:0], {FRAC_W{1'b0}}};
                  dvs_mag <= dvs_abs;
                  neg     <= bus.dividend[D_W-1] ^ bus.divisor[D_W-1];
                  zero    <= (bus.divisor == '0);
                  rem     <= '0;
                  mag     <= '0;
                  cnt     <= CNT_W'(N_W-1);
               end
            end
            ST_CALC: begin
               rem <= rem_ge ? rem_sub : rem_sh;
               mag <= {mag[N_W-2:0], rem_ge};
               num <= {num[N_W-2:0], 1'b0};
               cnt <= cnt - CNT_W'(1);
            end
            ST_FIN: begin
               quot_q <= q_nxt;
               ovf_q  <= ovf_nxt;
               dz_q   <= dz_nxt;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dz_q;

endmodule
